muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 clrn  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request strobe; sampled on the rising edge of clk.
REQ-005 alufunc  input  4  operation code: 1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU.
REQ-006 dataa  input  32  multiplicand for multiply; divisor for divide.
REQ-007 datab  input  32  multiplier for multiply; dividend for divide.
REQ-008 flush  input  1  synchronous abort of an operation in flight.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 done  output  1  one-cycle pulse; hi, lo and overflow are valid in the same cycle.
REQ-011 hi  output  32  multiply: product[63:32]; divide: remainder.
REQ-012 lo  output  32  multiply: product[31:0]; divide: quotient.
REQ-013 overflow  output  1  high only for a divide by zero; held until the next accepted start.

Function
REQ-014 States: IDLE, CALC, FIX, DONE.
REQ-015 The unit accepts a request only when start=1, state=IDLE and alufunc[3:2]=11; otherwise start is ignored.
REQ-016 On acceptance: latch the operands and the code, form operand magnitudes (signed codes only), clear the iteration counter, set busy=1, clear overflow, go to CALC.
REQ-017 CALC: run 32 radix-2 iterations, one per cycle (shift-add for multiply, restoring shift-subtract for divide), then go to FIX.
REQ-018 FIX: apply the sign correction, write hi and lo, go to DONE.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-020 Latency: with the start edge as edge N, done is high in the cycle that follows edge N+34.
REQ-021 Signed multiply: the 64-bit product is two's complement, negated when the operand signs differ.
REQ-022 Signed divide: the quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero (dataa=0, DIV or DIVU): skip CALC and FIX; hi=datab, lo=0xFFFFFFFF, overflow=1; done high in the cycle after edge N+1.
REQ-024 DIV 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, overflow=0.
REQ-025 flush=1 in any non-IDLE state returns the unit to IDLE on the next edge: no done pulse, hi, lo and overflow unchanged.
REQ-026 If flush and start are both high while in IDLE, flush wins and the request is not accepted.
REQ-027 Between operations, hi, lo and overflow hold their values.
REQ-028 Changes to dataa, datab or alufunc after acceptance have no effect on the result.

Reset
REQ-029 While clrn=0: state=IDLE, busy=0, done=0, overflow=0, hi=0, lo=0, counter=0; this takes effect immediately, without waiting for a clock edge.
REQ-030 Reset in the middle of an operation abandons it; no done pulse follows the release of reset.
REQ-031 The first start is honoured on the first rising edge of clk after clrn goes high.

Structure
REQ-032 Package muldiv_pkg holds:
- the four opcode constants (MULT, MULTU, DIV, DIVU);
- the state type;
- the constant ITER=32.
REQ-033 The opcode constants in muldiv_pkg match the ALU unit-11 function codes bit for bit.
REQ-034 One combinational sub-module, muldiv_step, performs a single multiply or divide iteration on {acc, operand register}.
REQ-035 Control and the sign handling stay in muldiv_unit.

Verification
REQ-036 MULTU, dataa=datab=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in the cycle after edge N+34.
REQ-037 MULT, dataa=0xFFFFFFFD, datab=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, overflow=0.
REQ-038 DIV, datab=0xFFFFFFF9, dataa=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-039 DIVU, dataa=0, datab=5 -> hi=5, lo=0xFFFFFFFF, overflow=1, done in the cycle after edge N+1; the next valid start clears overflow.
REQ-040 Three checks on request handling:
- start asserted while busy is ignored;
- flush at CALC iteration 10 -> IDLE, no done, hi and lo unchanged;
- clrn pulsed low in CALC -> all outputs 0 immediately.
REQ-041 DIV, datab=0x80000000, dataa=0xFFFFFFFF -> lo=0x80000000, hi=0, overflow=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative 32-bit multiply/divide unit.
// Opcodes are the ALU unit-11 function codes.
package muldiv_pkg;
  localparam int ITER = 32;

  localparam logic [3:0] MULT  = 4'b1100;
  localparam logic [3:0] MULTU = 4'b1101;
  localparam logic [3:0] DIV   = 4'b1110;
  localparam logic [3:0] DIVU  = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between a requester and muldiv_unit.
interface muldiv_if;
  logic        start;
  logic [3:0]  alufunc;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        overflow;

  modport master (output start, alufunc, dataa, datab, flush,
                  input  busy, done, hi, lo, overflow);
  modport slave  (input  start, alufunc, dataa, datab, flush,
                  output busy, done, hi, lo, overflow);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, opr}: shift-add multiply (multiplier in opr)
// or restoring shift-subtract divide (dividend in opr, quotient shifts in).
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc,
  input  logic [31:0] opr,
  input  logic [31:0] m,
  output logic [31:0] acc_nxt,
  output logic [31:0] opr_nxt
);
  logic [32:0] sum, trial;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, m};
    // acc < m always holds, so bit 32 of the trial is a clean borrow flag
    trial   = {acc, opr[31]} - {1'b0, m};
    acc_nxt = acc;
    opr_nxt = opr;
    if (is_div) begin
      if (trial[32]) begin
        acc_nxt = {acc[30:0], opr[31]};
        opr_nxt = {opr[30:0], 1'b0};
      end else begin
        acc_nxt = trial[31:0];
        opr_nxt = {opr[30:0], 1'b1};
      end
    end else if (opr[0]) begin
      {acc_nxt, opr_nxt} = {sum, opr[31:1]};
    end else begin
      {acc_nxt, opr_nxt} = {1'b0, acc, opr[31:1]};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU: magnitudes are formed on acceptance,
// 32 unsigned iterations run in CALC, signs are restored in FIX.
module muldiv_unit
  import muldiv_pkg::*;
(
  input logic     clk,
  input logic     clrn,
  muldiv_if.slave bus
);
  state_t      state, state_nxt;
  logic        is_div, dz, neg_q, neg_r, ovf_r, accept, sgn;
  logic [31:0] m_r, acc, opr, acc_s, opr_s, hi_r, lo_r;
  logic [63:0] prod;
  logic [5:0]  cnt;

  assign sgn    = ~bus.alufunc[0];
  assign accept = bus.start & ~bus.flush & (state == IDLE) & (bus.alufunc[3:2] == 2'b11);
  assign prod   = neg_q ? -{acc, opr} : {acc, opr};

  muldiv_step u_step (
    .is_div (is_div),
    .acc    (acc),
    .opr    (opr),
    .m      (m_r),
    .acc_nxt(acc_s),
    .opr_nxt(opr_s)
  );

  always_ff @(posedge clk or negedge clrn)
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (bus.flush && state != IDLE) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (accept) state_nxt = CALC;
        // divide by zero spends one cycle here and bypasses the iterations
        CALC: if (dz) state_nxt = DONE;
              else if (cnt == 6'(ITER)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      is_div <= 1'b0;
      dz     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      m_r    <= '0;
      acc    <= '0;
      opr    <= '0;
      cnt    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      is_div <= bus.alufunc[1];
      dz     <= bus.alufunc[1] && (bus.dataa == '0);
      neg_q  <= sgn & (bus.dataa[31] ^ bus.datab[31]);
      neg_r  <= sgn & bus.datab[31];
      m_r    <= mag(bus.dataa, sgn & bus.dataa[31]);
      opr    <= mag(bus.datab, sgn & bus.datab[31]);
      acc    <= '0;
      cnt    <= '0;
      ovf_r  <= 1'b0;
    end else if (!bus.flush) begin
      if (state == CALC) begin
        if (dz) begin
          // re-applying the dividend sign recovers the raw datab
          hi_r  <= neg_r ? -opr : opr;
          lo_r  <= '1;
          ovf_r <= 1'b1;
        end else if (cnt != 6'(ITER)) begin
          acc <= acc_s;
          opr <= opr_s;
          cnt <= cnt + 6'd1;
        end
      end else if (state == FIX) begin
        if (is_div) begin
          lo_r <= neg_q ? -opr : opr;
          hi_r <= neg_r ? -acc : acc;
        end else begin
          {hi_r, lo_r} <= prod;
        end
      end
    end
  end

  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.done     = (state == DONE);
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor
// pops and compares on every done pulse, including the arrival cycle.
module tb_muldiv_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        ov;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic clrn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [31:0] last_hi = '0, last_lo = '0;
  logic        last_ov = 1'b0;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .clrn(clrn),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb_, ua, ub, p, q, r;
    sa  = $signed(a);
    sb_ = $signed(b);
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    e.ov = 1'b0;
    e.due = 0;
    if (f[1] && a == 32'd0) begin
      e.hi = b;
      e.lo = 32'hFFFF_FFFF;
      e.ov = 1'b1;
    end else begin
      case (f)
        4'b1100: p = sa * sb_;
        4'b1101: p = ua * ub;
        4'b1110: begin q = sb_ / sa; r = sb_ % sa; p = {r[31:0], q[31:0]}; end
        default: begin q = ub / ua;  r = ub % ua;  p = {r[31:0], q[31:0]}; end
      endcase
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy && !bus.done) return;
      @(negedge clk);
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Drive one request at a negedge; return at the negedge after the start edge.
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input bit track, input bit use_k, input exp_t ek);
    exp_t e;
    wait_idle();
    bus.start = 1'b1;
    bus.alufunc = f;
    bus.dataa = a;
    bus.datab = b;
    if (track) begin
      e = use_k ? ek : model(f, a, b);
      e.due = cyc + 1 + ((f[1] && a == 32'd0) ? 1 : 34);
      sb.push_back(e);
      last_hi = e.hi;
      last_lo = e.lo;
      last_ov = e.ov;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.alufunc = 4'($urandom);
    bus.dataa = $urandom;
    bus.datab = $urandom;
  endtask

  task automatic send_k(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, input logic ov);
    exp_t k;
    k.hi = h; k.lo = l; k.ov = ov; k.due = 0;
    send(f, a, b, 1'b1, 1'b1, k);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (clrn === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("overflow", bus.overflow, e.ov);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t dummy;
    logic [3:0] f;
    logic [31:0] a, b;
    dummy = '{hi: 32'd0, lo: 32'd0, ov: 1'b0, due: 0};
    clrn = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.alufunc = '0; bus.dataa = '0; bus.datab = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 0);
    chk("rst_ovf", bus.overflow, 0);

    // first start is taken on the first edge after reset release
    clrn = 1'b1;
    send_k(4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    send_k(4'b1100, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    send_k(4'b1110, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    send_k(4'b1111, 32'd2, 32'hFFFF_FFF9, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    send_k(4'b1110, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    send_k(4'b1111, 32'd0, 32'd5, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ovf_held", {bus.overflow, bus.hi}, {1'b1, 32'd5});
    send(4'b1100, 32'd1234, 32'hFFFF_0000, 1'b1, 1'b0, dummy);
    chk("ovf_cleared_on_start", bus.overflow, 0);
    send(4'b1110, 32'd0, 32'h8000_0003, 1'b1, 1'b0, dummy);

    // start while busy must be ignored
    send(4'b1111, 32'd7, 32'd1000, 1'b1, 1'b0, dummy);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.alufunc = 4'b1101; bus.dataa = 32'd3; bus.datab = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_during_op", bus.busy, 1);

    // flush sampled on CALC iteration 10
    send(4'b1100, $urandom, $urandom, 1'b0, 1'b0, dummy);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_hilo", {bus.hi, bus.lo}, {last_hi, last_lo});
    chk("flush_ovf", bus.overflow, last_ov);
    repeat (40) @(negedge clk);

    // flush beats start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.alufunc = 4'b1100;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_beats_start", bus.busy, 0);

    // asynchronous reset mid-CALC
    send(4'b1110, $urandom, $urandom, 1'b0, 1'b0, dummy);
    repeat (5) @(negedge clk);
    #2 clrn = 1'b0;
    #1;
    chk("async_rst_busy_done", {bus.busy, bus.done}, 0);
    chk("async_rst_hilo", {bus.hi, bus.lo}, 0);
    chk("async_rst_ovf", bus.overflow, 0);
    last_hi = '0; last_lo = '0; last_ov = 1'b0;
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    send(4'b1101, 32'h0001_0001, 32'hDEAD_BEEF, 1'b1, 1'b0, dummy);

    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        f = 4'($urandom_range(0, 11));
        send(f, $urandom, $urandom, 1'b0, 1'b0, dummy);
        chk("invalid_code_ignored", bus.busy, 0);
      end else begin
        f = {2'b11, 2'($urandom_range(0, 3))};
        a = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
        b = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
        send(f, a, b, 1'b1, 1'b0, dummy);
      end
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
